uart_transmitter: RTL and testbench

// - 8N1 UART transmitter, the TX counterpart to the RX path. Byte-wide valid/ready input, small internal FIFO, serial uart_tx output.
// - Sits between core-side MMIO/debug logic and the board TX pin.
// - Frames: start bit (0), 8 data bits LSB first, STOP_BITS stop bits (1). Each bit lasts exactly BIT_INTERVAL clocks.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_fifo.sv | 71 +++++++
 rtl/uart_transmitter.sv | 146 ++++++++++++++
 tb/tb_uart_transmitter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default timing constants and TX framing states.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH = 8;

  // Defaults shared between the transmitter and the receiver.
  localparam int unsigned DEFAULT_BIT_INTERVAL     = 10000;
  localparam int unsigned DEFAULT_RECHECK_INTERVAL = 5000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO with show-ahead read data and asynchronous active-high reset.
module uart_tx_fifo #(
  parameter int unsigned Depth  = 4,
  parameter int unsigned Width  = 8,
  localparam int unsigned CountW = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [Width-1:0]  wdata_i,
  output logic [Width-1:0]  rdata_o,
  output logic [CountW-1:0] count_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic              do_push, do_pop;

  // Pointer and occupancy next-state; pushes when full and pops when empty are ignored.
  always_comb begin
    full_o   = (count_q == CountW'(Depth));
    empty_o  = (count_q == '0);
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CountW'(1);
      2'b01:   count_d = count_q - CountW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once the count says they are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/uart_transmitter.sv
// 8N1-style UART transmitter: byte FIFO in front of a start/data/stop framing FSM.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned BIT_INTERVAL = DEFAULT_BIT_INTERVAL,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [UART_DATA_WIDTH-1:0]         in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic                               uart_tx,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  uart_tx_state_t             state_q, state_d;
  logic [31:0]                clock_count_q, clock_count_d;
  logic [2:0]                 bit_index_q, bit_index_d;
  logic                       stop_index_q, stop_index_d;
  logic [UART_DATA_WIDTH-1:0] shift_q, shift_d;
  logic                       uart_tx_q, uart_tx_d;
  logic                       line_busy_q;

  logic                       fifo_pop;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [UART_DATA_WIDTH-1:0] fifo_rdata;
  logic                       bit_end;
  logic                       last_stop;

  uart_tx_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (UART_DATA_WIDTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (in_valid & in_ready),
    .pop_i   (fifo_pop),
    .wdata_i (in_data),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Ready comes from the registered count only, so a same-cycle pop never raises it.
  assign in_ready  = ~fifo_full;
  assign bit_end   = ((clock_count_q + 32'd1) >= BIT_INTERVAL);
  assign last_stop = (({31'd0, stop_index_q} + 32'd1) >= STOP_BITS);

  // Framing FSM next-state, bit timing and the registered line value for the current state.
  always_comb begin
    state_d       = state_q;
    clock_count_d = clock_count_q;
    bit_index_d   = bit_index_q;
    stop_index_d  = stop_index_q;
    shift_d       = shift_q;
    fifo_pop      = 1'b0;
    uart_tx_d     = 1'b1;
    unique case (state_q)
      IDLE: begin
        uart_tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          shift_d       = fifo_rdata;
          clock_count_d = '0;
          state_d       = START;
        end
      end
      START: begin
        uart_tx_d = 1'b0;
        if (!bit_end) begin
          clock_count_d = clock_count_q + 32'd1;
        end else begin
          clock_count_d = '0;
          bit_index_d   = '0;
          state_d       = DATA;
        end
      end
      DATA: begin
        uart_tx_d = shift_q[bit_index_q];
        if (!bit_end) begin
          clock_count_d = clock_count_q + 32'd1;
        end else begin
          clock_count_d = '0;
          if (bit_index_q == 3'd7) begin
            stop_index_d = 1'b0;
            state_d      = STOP;
          end else begin
            bit_index_d = bit_index_q + 3'd1;
          end
        end
      end
      STOP: begin
        uart_tx_d = 1'b1;
        if (!bit_end) begin
          clock_count_d = clock_count_q + 32'd1;
        end else begin
          clock_count_d = '0;
          if (!last_stop) begin
            stop_index_d = 1'b1;
          end else if (!fifo_empty) begin
            // Chain straight into the next frame so there is no idle gap on the line.
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters, shift register and the registered serial line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      clock_count_q <= '0;
      bit_index_q   <= '0;
      stop_index_q  <= 1'b0;
      shift_q       <= '0;
      uart_tx_q     <= 1'b1;
      line_busy_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      clock_count_q <= clock_count_d;
      bit_index_q   <= bit_index_d;
      stop_index_q  <= stop_index_d;
      shift_q       <= shift_d;
      uart_tx_q     <= uart_tx_d;
      line_busy_q   <= (state_q != IDLE);
    end
  end

  assign uart_tx = uart_tx_q;
  // line_busy_q keeps busy high while the final stop bit is still on the registered line.
  assign busy    = (state_q != IDLE) | (fifo_count != '0) | line_busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Randomised bench for uart_transmitter: queue-based frame model, line decoder, literal frame checks.
module tb_uart_transmitter;

  localparam int unsigned BI    = 4;
  localparam int unsigned DEPTH = 4;
  localparam int          CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    in_data [2];
  logic          in_valid [2];
  logic          ready [2];
  logic          tx [2];
  logic          busy [2];
  logic [CW-1:0] cnt [2];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  bit dec_en = 1'b0;

  // Behavioural model state: byte queue, per-cycle line samples still to be sent, frame timer.
  logic [7:0] fq [2][$];
  bit         lq [2][$];
  int         ft [2];
  int         acc [2];
  logic       in_frame [2];
  logic       exp_tx [2];
  logic       exp_busy [2];
  logic       exp_ready [2];
  int         exp_cnt [2];
  logic [7:0] dec_exp [$];
  logic [7:0] dec_log [$];
  int         dec_cnt = 0;

  uart_transmitter #(
    .BIT_INTERVAL (BI),
    .FIFO_DEPTH   (DEPTH),
    .STOP_BITS    (1)
  ) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data[0]),
    .in_valid   (in_valid[0]),
    .in_ready   (ready[0]),
    .uart_tx    (tx[0]),
    .busy       (busy[0]),
    .fifo_count (cnt[0])
  );

  uart_transmitter #(
    .BIT_INTERVAL (BI),
    .FIFO_DEPTH   (DEPTH),
    .STOP_BITS    (2)
  ) u_dut2 (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data[1]),
    .in_valid   (in_valid[1]),
    .in_ready   (ready[1]),
    .uart_tx    (tx[1]),
    .busy       (busy[1]),
    .fifo_count (cnt[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      fq[d].delete();
      lq[d].delete();
      ft[d]        = 0;
      in_frame[d]  = 1'b0;
      exp_tx[d]    = 1'b1;
      exp_busy[d]  = 1'b0;
      exp_ready[d] = 1'b1;
      exp_cnt[d]   = 0;
    end
    dec_exp.delete();
  endtask

  // One clock of the model: line samples are emitted one per clock in the cycle after the
  // frame is taken from the queue; frames occupy (9+stop) bit times back to back.
  task automatic model_step(input int d);
    int         pre;
    int         sb;
    logic [7:0] b;
    bit         v;
    pre = fq[d].size();
    sb  = (d == 0) ? 1 : 2;
    if (lq[d].size() > 0) begin
      exp_tx[d]   = lq[d].pop_front();
      in_frame[d] = 1'b1;
    end else begin
      exp_tx[d]   = 1'b1;
      in_frame[d] = 1'b0;
    end
    if (ft[d] > 0) ft[d]--;
    if (ft[d] == 0 && pre > 0) begin
      b     = fq[d].pop_front();
      ft[d] = (9 + sb) * BI;
      for (int k = 0; k < 9 + sb; k++) begin
        if (k == 0) v = 1'b0;
        else if (k <= 8) v = b[k-1];
        else v = 1'b1;
        for (int r = 0; r < BI; r++) lq[d].push_back(v);
      end
    end
    if (in_valid[d] && pre < DEPTH) begin
      fq[d].push_back(in_data[d]);
      acc[d]++;
      if (d == 0 && dec_en) dec_exp.push_back(in_data[d]);
    end
    exp_cnt[d]   = fq[d].size();
    exp_ready[d] = (fq[d].size() < DEPTH);
    exp_busy[d]  = (fq[d].size() != 0) || (ft[d] != 0) || in_frame[d];
  endtask

  initial begin : model
    acc[0] = 0;
    acc[1] = 0;
    model_clear();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_clear();
      else for (int d = 0; d < 2; d++) model_step(d);
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (cmp_en && !reset) begin
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("dut%0d_tx", d + 1), tx[d], exp_tx[d]);
          chk($sformatf("dut%0d_busy", d + 1), busy[d], exp_busy[d]);
          chk($sformatf("dut%0d_count", d + 1), cnt[d], exp_cnt[d]);
          chk($sformatf("dut%0d_ready", d + 1), ready[d], exp_ready[d]);
        end
      end
    end
  end

  // Mid-bit line sampler on the first transmitter, checked against accepted-byte order.
  initial begin : decoder
    logic       prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (dec_en && !reset && prev && !tx[0]) begin
        repeat (BI / 2) @(negedge clk);
        chk("dec_start", tx[0], 0);
        for (int i = 0; i < 8; i++) begin
          repeat (BI) @(negedge clk);
          b[i] = tx[0];
        end
        repeat (BI) @(negedge clk);
        chk("dec_stop", tx[0], 1);
        dec_cnt++;
        dec_log.push_back(b);
        chk("dec_pending", int'(dec_exp.size() > 0), 1);
        if (dec_exp.size() > 0) chk("dec_byte", b, dec_exp.pop_front());
        prev = 1'b1;
      end else begin
        prev = tx[0];
      end
    end
  end

  task automatic wait_idle(input int d, input int bound, input string name);
    int n;
    n = 0;
    while (busy[d] && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle"}, busy[d], 0);
  endtask

  // Push one byte into an idle transmitter and check latency, every line sample and busy span.
  task automatic frame_check(input int d, input logic [7:0] byte_v, input logic [10:0] fb,
                             input int nbits, input string name);
    int          lat;
    int          n;
    int          len;
    logic [43:0] got;
    len          = nbits * BI;
    in_valid[d]  = 1'b1;
    in_data[d]   = byte_v;
    @(negedge clk);
    in_valid[d]  = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (tx[d] !== 1'b0 && lat < 20);
    chk({name, "_latency"}, lat, 2);
    n   = 0;
    got = '0;
    while (busy[d] && n < 100) begin
      if (n < len) got[n] = tx[d];
      @(negedge clk);
      n++;
    end
    chk({name, "_busy_len"}, n, len);
    for (int i = 0; i < len; i++) chk($sformatf("%s_sample%0d", name, i), got[i], fb[i / BI]);
  endtask

  initial begin : stim
    int base;
    int a0;
    int n;
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    in_data[0]  = '0;
    in_data[1]  = '0;
    reset       = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_tx", tx[d], 1);
      chk("reset_busy", busy[d], 0);
      chk("reset_count", cnt[d], 0);
      chk("reset_ready", ready[d], 1);
    end
    reset  = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);

    // Single byte 0xA5: start, LSB-first data 1,0,1,0,0,1,0,1, one stop bit.
    dec_en = 1'b1;
    frame_check(0, 8'hA5, 11'b01101001010, 10, "a5");
    wait_idle(0, 10, "a5");

    // Back-to-back: six cycles of valid, only five fit.
    base = dec_cnt;
    for (int i = 0; i < 6; i++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 8'(i + 1);
      chk("b2b_ready", ready[0], int'(i < 5));
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    chk("b2b_count", cnt[0], 4);
    wait_idle(0, 300, "b2b");
    chk("b2b_decoded", dec_cnt - base, 5);
    for (int i = 0; i < 5; i++) begin
      if (base + i < dec_log.size()) chk("b2b_byte", dec_log[base + i], i + 1);
    end

    // Hold valid at full; occupancy stays at the top while frames drain and refill.
    for (int i = 1; i <= 200; i++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 8'($urandom);
      if (i >= 6) chk("full_count_range", int'(cnt[0] >= 3 && cnt[0] <= 4), 1);
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    wait_idle(0, 400, "full");

    // Reset during data bit 3 of 0x3C with two bytes still queued.
    dec_en      = 1'b0;
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h3C;
    @(negedge clk);
    in_data[0]  = 8'h11;
    @(negedge clk);
    in_data[0]  = 8'h22;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (17) @(negedge clk);
    chk("rst_pre_count", cnt[0], 2);
    chk("rst_pre_busy", busy[0], 1);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_tx", tx[0], 1);
    chk("rst_mid_count", cnt[0], 0);
    chk("rst_mid_busy", busy[0], 0);
    chk("rst_mid_ready", ready[0], 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    frame_check(0, 8'h55, 11'b01010101010, 10, "after_rst");
    wait_idle(0, 10, "after_rst");

    // Two stop bits, 0xFF: four low samples then forty high.
    frame_check(1, 8'hFF, 11'b11111111110, 11, "stop2");
    wait_idle(1, 10, "stop2");

    // Random traffic until 256 bytes have been accepted.
    dec_en = 1'b1;
    base   = dec_cnt;
    a0     = acc[0];
    n      = 0;
    while (acc[0] - a0 < 256 && n < 40000) begin
      in_valid[0] = ($urandom_range(0, 3) != 0);
      in_data[0]  = 8'($urandom);
      @(negedge clk);
      n++;
    end
    in_valid[0] = 1'b0;
    chk("rand_accepted", acc[0] - a0, 256);
    wait_idle(0, 400, "rand");
    repeat (2) @(negedge clk);
    chk("rand_decoded", dec_cnt - base, 256);
    chk("rand_pending", dec_exp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
